insmem_loader: RTL and testbench

- Write-side companion to the byte-addressed, little-endian instruction memory (256 x 8-bit).
- Accepts 32-bit instruction words over a valid/ready stream and serialises each word into four byte writes, least-significant byte at the lowest address.
- Used by the bench or boot path to program the instruction memory before fetch starts, instead of relying on a file preload.
- Tracks the write cursor, detects memory exhaustion and reports done/error.

---
 rtl/insmem_loader_pkg.sv | 28 ++
 rtl/insmem_byte_serializer.sv | 35 +++
 rtl/insmem_loader.sv | 122 ++++++++++++
 tb/tb_insmem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insmem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch/decode path.
package insmem_loader_pkg;

  // Instruction memory geometry
  localparam int INSMEM_DEPTH    = 256;
  localparam int BYTES_PER_INSTR = 4;

  // RISC-V major opcodes used by the fetch/decode path
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE
  } loader_state_t;

  // Major opcode field of an instruction word
  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/insmem_byte_serializer.sv
// Holds one 32-bit instruction word and walks it out LSB-first, one byte per step.
module insmem_byte_serializer
  import insmem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic [7:0]  byte_data,
  output logic        last_byte
);

  logic [31:0] word_q;

  // Capture a new word on load, otherwise step the byte index while writing
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (load) begin
      word_q   <= word;
      byte_idx <= '0;
    end else if (advance) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign byte_data = word_q[8*byte_idx +: 8];
  assign last_byte = (byte_idx == 2'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/insmem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory,
// little-endian, tracking the cursor and flagging capacity exhaustion.
module insmem_loader
  import insmem_loader_pkg::*;
#(
  parameter  int ADDR_W    = 8,
  parameter  int WORD_W    = 32,
  parameter  int MAX_WORDS = 64,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_INSTR - 1);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(BYTES_PER_INSTR);
  localparam logic [CNT_W-1:0]  FINAL_SLOT = CNT_W'(MAX_WORDS - 1);

  loader_state_t     state, next_state;
  logic [ADDR_W-1:0] cursor;
  logic [ADDR_W-1:0] addr_hold;
  logic [7:0]        data_hold;
  logic              last_q;
  logic              start_take;
  logic              accept;
  logic              writing;
  logic [1:0]        byte_idx;
  logic [7:0]        byte_data;
  logic              last_byte;
  logic [ADDR_W-1:0] cur_addr;

  assign start_take = start && (state == ST_IDLE || state == ST_DONE);
  assign accept     = word_valid && (state == ST_ACCEPT);
  assign writing    = (state == ST_WRITE);
  assign cur_addr   = cursor + ADDR_W'(byte_idx);

  insmem_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .advance   (writing),
    .word      (word_data),
    .byte_idx  (byte_idx),
    .byte_data (byte_data),
    .last_byte (last_byte)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start) next_state = ST_ACCEPT;
      ST_ACCEPT: if (word_valid) next_state = ST_WRITE;
      ST_WRITE: begin
        if (last_byte) begin
          if (last_q || word_count == FINAL_SLOT) next_state = ST_DONE;
          else                                    next_state = ST_ACCEPT;
        end
      end
      ST_DONE:   if (start) next_state = ST_ACCEPT;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Session cursor, word counter, sticky overflow and write-port hold registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor     <= '0;
      word_count <= '0;
      err        <= 1'b0;
      last_q     <= 1'b0;
      addr_hold  <= '0;
      data_hold  <= '0;
    end else begin
      if (start_take) begin
        cursor     <= base_addr & ALIGN_MASK;
        word_count <= '0;
        err        <= 1'b0;
      end
      if (accept) last_q <= word_last;
      if (writing) begin
        addr_hold <= cur_addr;
        data_hold <= byte_data;
        if (last_byte) begin
          cursor     <= cursor + WORD_STEP;
          word_count <= word_count + 1'b1;
          // Memory filled without a terminating word: the stream overran capacity
          err        <= err | (!last_q && word_count == FINAL_SLOT);
        end
      end
    end
  end

  // Write port is live only in WRITE; otherwise it shows the last written byte
  assign mem_we     = writing;
  assign mem_addr   = writing ? cur_addr  : addr_hold;
  assign mem_wdata  = writing ? byte_data : data_hold;
  assign word_ready = (state == ST_ACCEPT);
  assign busy       = (state == ST_ACCEPT) || writing;
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_insmem_loader.sv
// Scoreboard bench for insmem_loader: expected byte writes are queued as words
// are accepted and matched against the write port as the loader emits them.
module tb_insmem_loader;
  import insmem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [31:0] word_data = '0;
  logic        word_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  word_count;

  insmem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_cursor = '0;
  logic [7:0] tb_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Instruction memory model: commits a byte on the edge that ends a write cycle
  always @(posedge clk) if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;

  // Write-port monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_we", {31'd0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_start(input logic [7:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    model_cursor = base & 8'hFC;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one word; on acceptance queue its four expected byte writes
  task automatic send_word(input logic [31:0] data, input logic last, input int max_wait,
                           output bit accepted, output int acc_edge, output int waited);
    accepted = 1'b0;
    acc_edge = 0;
    waited = 0;
    word_valid = 1'b1;
    word_data = data;
    word_last = last;
    while (!accepted && waited < max_wait) begin
      @(negedge clk);
      if (word_ready === 1'b1) begin
        accepted = 1'b1;
        acc_edge = cyc + 1;
        for (int i = 0; i < 4; i++) begin
          wr_t e;
          e.addr = model_cursor + 8'(i);
          e.data = data[8*i +: 8];
          e.cyc  = acc_edge + i;
          sb.push_back(e);
        end
        model_cursor = model_cursor + 8'd4;
      end else begin
        waited++;
      end
    end
    if (accepted) begin
      @(posedge clk); #1;
    end
    word_valid = 1'b0;
    word_last = 1'b0;
  endtask

  task automatic send_ok(input string tag, input logic [31:0] data, input logic last);
    bit ok;
    int e, w;
    send_word(data, last, 50, ok, e, w);
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] fetch(input logic [7:0] a);
    return {tb_mem[a + 8'd3], tb_mem[a + 8'd2], tb_mem[a + 8'd1], tb_mem[a]};
  endfunction

  initial begin
    bit ok;
    int e1, e2, w1, w2, n;
    logic [31:0] f;

    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;

    // Reset values
    #1;
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_ready", {31'd0, word_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_count", {25'd0, word_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single word at base 0
    do_start(8'h00);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_ok("t1_accept", 32'h00500093, 1'b1);
    wait_done("t1_done");
    check("t1_count", {25'd0, word_count}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    check("t1_hold_addr", {24'd0, mem_addr}, 32'h03);
    check("t1_hold_data", {24'd0, mem_wdata}, 32'h00);
    check("t1_sb_empty", sb.size(), 32'd0);
    f = fetch(8'h00);
    check("t1_opcode", {25'd0, opcode_of(f)}, {25'd0, OP_I});
    check("t1_rd", {27'd0, f[11:7]}, 32'd1);
    check("t1_imm", {20'd0, f[31:20]}, 32'd5);

    // Misaligned base, back-to-back words
    do_start(8'h13);
    send_word(32'h002081B3, 1'b0, 50, ok, e1, w1);
    check("t2_acc1", {31'd0, ok}, 32'd1);
    send_word(32'h00A13023, 1'b1, 50, ok, e2, w2);
    check("t2_acc2", {31'd0, ok}, 32'd1);
    check("t2_ready_gap", w2, 32'd4);
    check("t2_accept_period", e2 - e1, 32'd5);
    wait_done("t2_done");
    check("t2_count", {25'd0, word_count}, 32'd2);
    check("t2_mem10", fetch(8'h10), 32'h002081B3);
    f = fetch(8'h14);
    check("t2_opcode", {25'd0, opcode_of(f)}, {25'd0, OP_SD});

    // Address wrap from 0xFC
    do_start(8'hFC);
    send_ok("t3_acc1", 32'h11223344, 1'b0);
    send_ok("t3_acc2", 32'h55667788, 1'b1);
    wait_done("t3_done");
    check("t3_err", {31'd0, err}, 32'd0);
    check("t3_count", {25'd0, word_count}, 32'd2);
    check("t3_memFC", fetch(8'hFC), 32'h11223344);
    check("t3_mem00", fetch(8'h00), 32'h55667788);

    // Asynchronous reset in the middle of byte 2
    do_start(8'h40);
    send_ok("t5_accept", 32'hA1B2C3D4, 1'b1);
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == 8'h42) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_byte2", {24'd0, mem_addr}, 32'h42);
    #2 reset = 1'b1;
    #1;
    check("t5_we", {31'd0, mem_we}, 32'd0);
    check("t5_ready", {31'd0, word_ready}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_addr", {24'd0, mem_addr}, 32'd0);
    check("t5_wdata", {24'd0, mem_wdata}, 32'd0);
    check("t5_count", {25'd0, word_count}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("t5_mem40", {24'd0, tb_mem[8'h40]}, 32'hD4);
    check("t5_mem41", {24'd0, tb_mem[8'h41]}, 32'hC3);
    check("t5_mem42", {24'd0, tb_mem[8'h42]}, 32'h00);
    do_start(8'h80);
    send_ok("t5_new_accept", 32'hCAFEF00D, 1'b1);
    wait_done("t5_new_done");
    check("t5_new_count", {25'd0, word_count}, 32'd1);
    check("t5_new_mem", fetch(8'h80), 32'hCAFEF00D);

    // start during WRITE and valid held in DONE are ignored
    do_start(8'h20);
    send_ok("t6_acc1", 32'h0000A063, 1'b0);
    start = 1'b1;
    base_addr = 8'h90;
    @(posedge clk); #1;
    start = 1'b0;
    send_ok("t6_acc2", 32'h00B50533, 1'b1);
    wait_done("t6_done");
    check("t6_count", {25'd0, word_count}, 32'd2);
    check("t6_mem24", fetch(8'h24), 32'h00B50533);
    word_valid = 1'b1;
    word_data = 32'hDEADBEEF;
    repeat (10) @(negedge clk);
    check("t6_hold_count", {25'd0, word_count}, 32'd2);
    check("t6_hold_done", {31'd0, done}, 32'd1);
    check("t6_hold_ready", {31'd0, word_ready}, 32'd0);
    word_valid = 1'b0;

    // 65 words without last from base 0: capacity overflow
    do_start(8'h00);
    for (int i = 0; i < 64; i++) begin
      send_word(32'h10000000 + 32'(i), 1'b0, 50, ok, e1, w1);
      if (!ok) check("t4_accept", {31'd0, ok}, 32'd1);
    end
    send_word(32'hFFFF0000, 1'b0, 20, ok, e1, w1);
    check("t4_w65_rejected", {31'd0, ok}, 32'd0);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_count", {25'd0, word_count}, 32'd64);
    check("t4_ready", {31'd0, word_ready}, 32'd0);
    check("t4_sb_empty", sb.size(), 32'd0);
    check("t4_mem_last", fetch(8'hFC), 32'h1000003F);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so a stuck handshake still ends with a report
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
